// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front-end and display stages.
package stopwatch_pkg;

    // FSM state encoding, also exported on state_o.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } sw_state_t;

    // Board defaults: 50 MHz clock, 100 Hz tick, 10 ms debounce.
    localparam int TICK_DIV_DEFAULT  = 500000;
    localparam int DB_CYCLES_DEFAULT = 500000;

    // Active-low 7-segment pattern for one decimal digit, bit order gfedcba.
    // Non-decimal codes blank the digit.
    function automatic logic [6:0] seg7_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_tick_ctrl_btn_debounce.sv
// One push-button input path: 2-FF synchroniser, polarity normalisation,
// debounce counter and a registered one-cycle press pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int              CW           = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST     = CW'(DB_CYCLES - 1);
    localparam logic            RELEASED_RAW = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1, sync2;
    logic          level;      // synchronised level, 1 = pressed
    logic          db_level;   // debounced level, 1 = pressed
    logic          db_level_d; // debounced level one cycle late, for edge detect
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain; reset parks it at "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign level = sync2 ^ RELEASED_RAW;

    // Count consecutive disagreeing samples; accept the new level after DB_CYCLES of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            db_level <= 1'b0;
        end else if (level != db_level) begin
            if (cnt == CNT_LAST) begin
                cnt      <= '0;
                db_level <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Registered pulse on the released-to-pressed flip only; releases are silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level_d <= 1'b0;
            press      <= 1'b0;
        end else begin
            db_level_d <= db_level;
            press      <= db_level & ~db_level_d;
        end
    end

endmodule

// File: rtl/stopwatch_tick_ctrl.sv
// Stopwatch front-end: debounced buttons, run/pause/lap FSM and the
// 1/100 s tick prescaler that drives the downstream time counter.
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int DB_CYCLES      = DB_CYCLES_DEFAULT,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       tick_o,
    output logic       running_o,
    output logic       freeze_o,
    output logic       clear_o,
    output logic [1:0] state_o
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          start_press, clear_press, lap_press;
    sw_state_t     state_q, state_n;
    logic          clear_n;
    logic          counting;
    logic [PW-1:0] presc_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_press)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next state and clear request; start outranks clear, clear outranks lap.
    always_comb begin
        state_n = state_q;
        clear_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_press)      state_n = RUN;
                else if (clear_press) clear_n = 1'b1;
            end
            RUN: begin
                if (start_press)      state_n = PAUSED;
                else if (lap_press)   state_n = LAP;
            end
            LAP: begin
                if (start_press)      state_n = PAUSED;
                else if (lap_press)   state_n = RUN;
            end
            PAUSED: begin
                if (start_press) begin
                    state_n = RUN;
                end else if (clear_press) begin
                    state_n = IDLE;
                    clear_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign state_o  = state_q;

    // Status outputs registered from the next state so they change with state_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_o <= 1'b0;
            freeze_o  <= 1'b0;
            clear_o   <= 1'b0;
        end else begin
            running_o <= (state_n == RUN) || (state_n == LAP);
            freeze_o  <= (state_n == LAP);
            clear_o   <= clear_n;
        end
    end

    // Prescaler advances while counting, holds its fraction when paused, and
    // ticks on wrap; a wrap on the pausing edge still issues its tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            tick_o  <= 1'b0;
        end else begin
            if (clear_n)       presc_q <= '0;
            else if (counting) presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            tick_o <= counting && (presc_q == PRESC_LAST);
        end
    end

endmodule

// File: tb/tb_stopwatch_tick_ctrl.sv
// Bench for stopwatch_tick_ctrl with TICK_DIV=10, DB_CYCLES=4, active-low buttons.
module tb_stopwatch_tick_ctrl;

    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_clear, btn_lap;
    logic       tick_o, running_o, freeze_o, clear_o;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int tick_seen = 0;
    int clr_seen = 0;

    stopwatch_tick_ctrl #(.TICK_DIV(TD), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .tick_o    (tick_o),
        .running_o (running_o),
        .freeze_o  (freeze_o),
        .clear_o   (clear_o),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buttons: index 0 start, 1 clear, 2 lap. hist holds pressed samples, bit0 newest.
    bit [DB+1:0] m_hist [3];
    bit          m_db [3];
    bit          m_d1 [3];
    bit          m_d2 [3];
    bit          m_act [3];
    bit          m_raw [3];
    int          m_state, m_presc;
    bit          m_tick, m_run, m_frz, m_clr, m_valid, m_oldrun;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = '0; m_db[b] = 0; m_d1[b] = 0; m_d2[b] = 0;
            end
            m_state = 0; m_presc = 0;
            m_tick = 0; m_run = 0; m_frz = 0; m_clr = 0;
            m_valid = 1;
        end else begin
            m_raw[0] = ~btn_start;
            m_raw[1] = ~btn_clear;
            m_raw[2] = ~btn_lap;
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][DB:0], m_raw[b]};
                m_act[b]  = m_d2[b];
                m_d2[b]   = m_d1[b];
                m_d1[b]   = 0;
                // The level seen by the debouncer lags the pin by two samples;
                // it is accepted once DB consecutive samples disagree with it.
                if (m_hist[b][DB+1:2] == {DB{1'b1}} && !m_db[b]) begin
                    m_db[b] = 1; m_d1[b] = 1;
                end else if (m_hist[b][DB+1:2] == {DB{1'b0}} && m_db[b]) begin
                    m_db[b] = 0;
                end
            end
            m_oldrun = (m_state == 1) || (m_state == 3);
            m_tick   = m_oldrun && (m_presc == TD - 1);
            if (m_oldrun) m_presc = (m_presc + 1) % TD;
            m_clr = 0;
            case (m_state)
                0: if (m_act[0]) m_state = 1; else if (m_act[1]) m_clr = 1;
                1: if (m_act[0]) m_state = 2; else if (m_act[2]) m_state = 3;
                3: if (m_act[0]) m_state = 2; else if (m_act[2]) m_state = 1;
                default: if (m_act[0]) m_state = 1;
                         else if (m_act[1]) begin m_state = 0; m_clr = 1; end
            endcase
            if (m_clr) m_presc = 0;
            m_run = (m_state == 1) || (m_state == 3);
            m_frz = (m_state == 3);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset === 1'b0 && m_valid) begin
            chk("cyc_tick",    tick_o,    m_tick);
            chk("cyc_running", running_o, m_run);
            chk("cyc_freeze",  freeze_o,  m_frz);
            chk("cyc_clear",   clear_o,   m_clr);
            chk("cyc_state",   state_o,   m_state);
        end
    end

    // Pulse counters sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (reset === 1'b0) begin
            if (tick_o === 1'b1)  tick_seen++;
            if (clear_o === 1'b1) clr_seen++;
        end
    end

    task automatic set_btn(input int which, input logic pressed);
        case (which)
            0: btn_start = ~pressed;
            1: btn_clear = ~pressed;
            default: btn_lap = ~pressed;
        endcase
    endtask

    // Press for 10 samples, release, and let the release settle.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (10) @(negedge clk);
        set_btn(which, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    int t0, c0;

    initial begin
        btn_start = 1'b1; btn_clear = 1'b1; btn_lap = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tick", tick_o, 0);
        chk("rst_running", running_o, 0);
        chk("rst_freeze", freeze_o, 0);
        chk("rst_clear", clear_o, 0);
        chk("rst_state", state_o, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Glitches of 1, 2 and 3 samples never reach the debounce threshold.
        btn_start = 1'b0; @(negedge clk); btn_start = 1'b1; @(negedge clk);
        btn_start = 1'b0; repeat (2) @(negedge clk); btn_start = 1'b1; @(negedge clk);
        btn_start = 1'b0; repeat (3) @(negedge clk); btn_start = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_state", state_o, 0);
        chk("glitch_ticks", tick_seen, 0);

        // Start: RUN at k+7, first tick 10 cycles later, then every 10.
        btn_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("start_run_k6", running_o, 0);
        @(negedge clk);
        chk("start_run_k7", running_o, 1);
        chk("start_state", state_o, 1);
        repeat (2) @(negedge clk);
        btn_start = 1'b1;
        repeat (7) @(negedge clk);
        chk("tick_before_first", tick_o, 0);
        @(negedge clk);
        chk("tick_first", tick_o, 1);
        @(negedge clk);
        chk("tick_width", tick_o, 0);
        repeat (9) @(negedge clk);
        chk("tick_second", tick_o, 1);

        // Pause with the prescaler at 6, then resume: tick 4 cycles after RUN.
        repeat (8) @(negedge clk);
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pause_state", state_o, 2);
        chk("pause_running", running_o, 0);
        repeat (2) @(negedge clk);
        btn_start = 1'b1;
        t0 = tick_seen;
        repeat (50) @(negedge clk);
        chk("pause_no_tick", tick_seen - t0, 0);
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("resume_running", running_o, 1);
        repeat (3) @(negedge clk);
        chk("resume_tick_r3", tick_o, 0);
        @(negedge clk);
        chk("resume_tick_r4", tick_o, 1);
        btn_start = 1'b1;
        repeat (10) @(negedge clk);

        // Clear is ignored while running; honoured from PAUSED.
        c0 = clr_seen;
        press(1);
        chk("clear_run_state", state_o, 1);
        chk("clear_run_no_pulse", clr_seen - c0, 0);
        press(0);
        chk("clear_paused_pre", state_o, 2);
        c0 = clr_seen;
        press(1);
        chk("clear_one_pulse", clr_seen - c0, 1);
        chk("clear_state", state_o, 0);
        btn_start = 1'b0;
        repeat (8) @(negedge clk);
        chk("restart_running", running_o, 1);
        repeat (9) @(negedge clk);
        chk("restart_tick_r9", tick_o, 0);
        @(negedge clk);
        chk("restart_tick_r10", tick_o, 1);
        btn_start = 1'b1;
        repeat (10) @(negedge clk);

        // Lap holds the display while ticks keep coming.
        t0 = tick_seen;
        press(2);
        chk("lap_ticks", tick_seen - t0, 2);
        chk("lap_state", state_o, 3);
        chk("lap_freeze", freeze_o, 1);
        press(2);
        chk("unlap_state", state_o, 1);
        chk("unlap_freeze", freeze_o, 0);
        press(2);
        press(0);
        chk("lap_start_state", state_o, 2);
        chk("lap_start_freeze", freeze_o, 0);

        // Asynchronous reset mid-run, with start held through release.
        press(0);
        chk("prereset_running", running_o, 1);
        btn_start = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("areset_tick", tick_o, 0);
        chk("areset_running", running_o, 0);
        chk("areset_freeze", freeze_o, 0);
        chk("areset_clear", clear_o, 0);
        chk("areset_state", state_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (7) @(negedge clk);
        chk("held_run_k6", running_o, 0);
        @(negedge clk);
        chk("held_run_k7", running_o, 1);
        repeat (30) @(negedge clk);
        chk("held_single_press", state_o, 1);
        btn_start = 1'b1;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
